// File: rtl/vib_pkg.sv
// rtl/vib_pkg.sv - shared constants and state encodings for the vibration FFT path
package vib_pkg;
    localparam int FFT_LEN    = 64;
    localparam int SAMPLE_W   = 8;
    localparam int BIN_W      = 11;
    localparam int MAG_W      = 2 * BIN_W;
    localparam int FIFO_DEPTH = 32;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        KEEP      = 2'd1,
        SKIP      = 2'd2
    } seq_state_t;
endpackage

// File: rtl/bin_fifo.sv
// rtl/bin_fifo.sv - single-clock FIFO for magnitude bins awaiting the UART
module bin_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 32
) (
    input  logic             sys_clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - paces the FFT from accel samples, keeps positive bins, feeds UART
module fft_frame_sequencer #(
    parameter int FFT_LEN    = vib_pkg::FFT_LEN,
    parameter int SAMPLE_W   = vib_pkg::SAMPLE_W,
    parameter int BIN_W      = vib_pkg::BIN_W,
    parameter int FIFO_DEPTH = vib_pkg::FIFO_DEPTH
) (
    input  logic                  sys_clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  accel_osync,
    input  logic [SAMPLE_W-1:0]   accel_data,
    output logic                  fft_ce,
    output logic [2*SAMPLE_W-1:0] fft_sample,
    input  logic [2*BIN_W-1:0]    fft_result,
    input  logic                  fft_osync,
    output logic [2*BIN_W-1:0]    uart_word,
    output logic                  uart_valid,
    input  logic                  uart_busy,
    output logic                  frame_done,
    output logic [7:0]            frame_count,
    output logic                  overflow,
    output logic [1:0]            state
);
    import vib_pkg::*;

    localparam int MW    = 2 * BIN_W;
    localparam int CNT_W = $clog2(FFT_LEN);
    localparam logic [CNT_W-1:0] LAST_KEEP = CNT_W'(FFT_LEN / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_BIN  = CNT_W'(FFT_LEN - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] bin_cnt_q, bin_cnt_d;
    logic             osync_prev;
    logic             accel_rise;
    logic             capture, capture_last;
    logic             push_q, last_q;
    logic [MW-1:0]    mag, mag_q;
    logic signed [MW-1:0] re_x, im_x, re_sq, im_sq;
    logic             fifo_full, fifo_empty, pop;

    assign accel_rise = accel_osync & ~osync_prev;

    // Sign-extend before squaring so the product is taken at full magnitude width.
    assign re_x  = {{BIN_W{fft_result[MW-1]}}, fft_result[MW-1:BIN_W]};
    assign im_x  = {{BIN_W{fft_result[BIN_W-1]}}, fft_result[BIN_W-1:0]};
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;
    assign mag   = re_sq + im_sq;

    always_comb begin
        state_d      = state_q;
        bin_cnt_d    = bin_cnt_q;
        capture      = 1'b0;
        capture_last = 1'b0;
        if (fft_ce) begin
            if (fft_osync) begin
                capture   = 1'b1;
                state_d   = KEEP;
                bin_cnt_d = CNT_W'(1);
            end else begin
                case (state_q)
                    KEEP: begin
                        capture   = 1'b1;
                        bin_cnt_d = bin_cnt_q + 1'b1;
                        if (bin_cnt_q == LAST_KEEP) begin
                            capture_last = 1'b1;
                            state_d      = SKIP;
                        end
                    end
                    SKIP: begin
                        bin_cnt_d = bin_cnt_q + 1'b1;
                        if (bin_cnt_q == LAST_BIN) begin
                            state_d   = KEEP;
                            bin_cnt_d = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            osync_prev  <= 1'b0;
            fft_ce      <= 1'b0;
            fft_sample  <= '0;
            state_q     <= WAIT_SYNC;
            bin_cnt_q   <= '0;
            push_q      <= 1'b0;
            last_q      <= 1'b0;
            mag_q       <= '0;
            frame_count <= '0;
            overflow    <= 1'b0;
        end else begin
            osync_prev <= accel_osync;
            fft_ce     <= accel_rise & enable;
            if (accel_rise & enable) fft_sample <= {accel_data, {SAMPLE_W{1'b0}}};
            state_q    <= state_d;
            bin_cnt_q  <= bin_cnt_d;
            push_q     <= capture;
            last_q     <= capture_last;
            if (capture) mag_q <= mag;
            if (frame_done) frame_count <= frame_count + 8'd1;
            if (push_q & fifo_full & ~pop) overflow <= 1'b1;
        end
    end

    assign frame_done = push_q & last_q;
    assign state      = state_q;
    assign uart_valid = ~fifo_empty;
    assign pop        = ~fifo_empty & ~uart_busy;

    bin_fifo #(
        .WIDTH(MW),
        .DEPTH(FIFO_DEPTH)
    ) u_bin_fifo (
        .sys_clock(sys_clock),
        .reset    (reset),
        .push     (push_q),
        .din      (mag_q),
        .pop      (pop),
        .dout     (uart_word),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );
endmodule
